cp_remove: RTL and testbench
============================

# cp_remove

Receive-side cyclic-prefix remover for the OFDM modem. It takes the time-domain sample stream after symbol timing, where `in_sop` marks the first CP sample of each symbol. It discards the prefix and emits exactly `N_FFT` samples per symbol, framed with `out_sop`/`out_eop`, to the FFT input. A programmable back-off moves the FFT window earlier into the prefix to give ISI margin against timing error.

## Interface
Parameters:
- `N_FFT`, 1024: useful samples per symbol, output per symbol.
- `CP_LEN`, 32: cyclic-prefix length in samples; symbol length on input is `CP_LEN+N_FFT`.
- `DW`, 20: width of each of I and Q, signed two's complement.

Ports (clock and reset first):
- `clk`  in  1  single clock. Everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  clock enable. When 0, all state and outputs hold and inputs are ignored.
- `in_valid`  in  1  input sample strobe.
- `in_sop`  in  1  first CP sample of a symbol. Qualified by `in_valid`.
- `in_i`, `in_q`  in  DW each  input sample.
- `backoff`  in  clog2(CP_LEN)  window back-off in samples, range 0..CP_LEN-1. Sampled only on an accepted `in_sop`.
- `out_valid`  out  1  output sample strobe.
- `out_sop`  out  1  first useful sample of a symbol.
- `out_eop`  out  1  last (N_FFT-th) useful sample.
- `out_i`, `out_q`  out  DW each  output sample.
- `sym_err`  out  1  one-cycle pulse on framing error.

## Operation
- An input sample is accepted on a cycle with `en && in_valid`. Cycles without acceptance leave the FSM and counter unchanged (gaps allowed anywhere).
- Per symbol, the block latches `bo = backoff` at the sop and sets drop count `D = CP_LEN - bo` (range 1..CP_LEN).
- Sample index k = 0..CP_LEN+N_FFT-1 counts accepted samples from the sop sample (k=0).
- Samples with k < D are dropped.
- Samples with D <= k < D+N_FFT are passed through.
- Samples with k >= D+N_FFT (the last `bo` samples) are dropped.
- FSM states:
  - IDLE: waits for an accepted sop; goes to SKIP with the sop sample counted as k=0 and dropped.
  - SKIP: drops samples until k = D-1, then goes to PASS.
  - PASS: forwards N_FFT samples. After the last one, goes to TAIL if bo>0, else IDLE.
  - TAIL: drops bo samples, then goes to IDLE.
- The sample counter is clog2(CP_LEN+N_FFT) bits, cleared on sop. The pass counter is clog2(N_FFT) bits and wraps exactly at N_FFT-1.
- Accepted samples with no sop in IDLE are dropped silently. No error is raised (pre-sync stream).
- Accepted sop in SKIP, PASS or TAIL:
  - `sym_err` pulses.
  - The current symbol is abandoned. No `out_eop` is issued for it.
  - The new sample is treated as k=0 of a new symbol, with `backoff` re-latched.
- A sop on the cycle immediately after the last sample of the previous symbol (back-to-back symbols) is legal and raises no error.
- Data passes bit-exact. No arithmetic is applied to I/Q.

## Timing
- Latency: 1 cycle. An accepted sample at edge t appears on `out_*` with `out_valid`=1 after edge t+1 (registered outputs).
- `out_sop` and `out_eop` are asserted only together with `out_valid`. Neither is ever asserted on the same beat as the other (N_FFT>1).
- `out_valid`, `out_sop`, `out_eop` and `sym_err` are single-cycle per event and low otherwise.
- `out_i`/`out_q` hold their last value when `out_valid`=0.
- With `en`=0, all outputs hold their previous value, including strobes. An `en`=0 cycle stretches nothing: the strobes are 1-cycle in enabled time.
- Reset (any state, including mid-PASS): FSM to IDLE and counters cleared. `out_valid`, `out_sop`, `out_eop`, `sym_err`, `out_i` and `out_q` are all 0 on the cycle after `rst`. `rst` overrides `en`.
- The first symbol after reset requires a fresh sop.

## Test plan
- Single symbol, backoff=0, contiguous valid, in_i=k, in_q=-k: outputs are in_i=32..1055 on 1024 consecutive cycles. `out_sop` is with 32 and `out_eop` is with 1055. The first output comes 33 cycles after the sop edge.
- backoff=8: outputs are in_i=24..1047. The last 8 samples are dropped. The FSM returns to IDLE after k=1055.
- Three back-to-back symbols with no gap and backoffs 0, 31, 5:
  - each yields exactly 1024 outputs with correct sop/eop;
  - `sym_err` never pulses;
  - the per-symbol backoff is honoured.
- Random `in_valid` gaps (~30%) and random `en` low cycles: the output sequence is identical to the gapless case, and strobes are never duplicated.
- sop injected at k=500 (in PASS): `sym_err` pulses once, no `out_eop` is issued for the old symbol, and the new symbol outputs its k=32.. samples correctly.
- `rst` asserted during PASS at output 300: all outputs are 0 on the next cycle. Data without sop afterwards produces no output. The next sop restarts normally.

Source files
------------

// File: rtl/cp_remove.sv
// cp_remove: drops the cyclic prefix of each OFDM symbol and frames
// N_FFT useful samples (sop/eop) for the FFT, with a per-symbol back-off.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                clock enable, holds all state and outputs when low
//   in_valid, in_sop  input strobe, first-CP-sample marker
//   in_i, in_q        input sample (signed)
//   backoff           window back-off, latched on an accepted sop
//   out_valid         output strobe
//   out_sop, out_eop  first / last useful sample of a symbol
//   out_i, out_q      output sample, held while out_valid is low
//   sym_err           one-cycle pulse when a sop cuts a symbol short
module cp_remove #(
  parameter int N_FFT  = 1024,
  parameter int CP_LEN = 32,
  parameter int DW     = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic                        in_sop,
  input  logic signed [DW-1:0]        in_i,
  input  logic signed [DW-1:0]        in_q,
  input  logic [$clog2(CP_LEN)-1:0]   backoff,
  output logic                        out_valid,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic signed [DW-1:0]        out_i,
  output logic signed [DW-1:0]        out_q,
  output logic                        sym_err
);

  localparam int BW = $clog2(CP_LEN);
  localparam int KW = $clog2(CP_LEN + N_FFT);
  localparam int PW = $clog2(N_FFT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_PASS,
    S_TAIL
  } state_t;

  state_t        r_state;
  // index k of the next accepted sample within the symbol
  logic [KW-1:0] r_k;
  logic [PW-1:0] r_pcnt;
  logic [BW-1:0] r_bo;
  // drop count D = CP_LEN - bo, needs one extra bit for D = CP_LEN
  logic [BW:0]   r_d;

  logic          w_acc;
  logic          w_sop;
  logic          w_pass;
  logic          w_last;
  logic          w_skip_end;
  logic          w_tail_end;
  logic [BW:0]   w_d;

  assign w_acc      = en & in_valid;
  assign w_sop      = w_acc & in_sop;
  assign w_d        = (BW+1)'(CP_LEN) - {1'b0, backoff};
  assign w_pass     = w_acc & ~in_sop & (r_state == S_PASS);
  assign w_last     = (r_pcnt == PW'(N_FFT - 1));
  assign w_skip_end = (r_k == KW'(r_d) - KW'(1));
  assign w_tail_end = (r_k == KW'(CP_LEN + N_FFT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_pcnt    <= '0;
      r_bo      <= '0;
      r_d       <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      sym_err   <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
    end else if (en) begin
      out_valid <= w_pass;
      out_sop   <= w_pass & (r_pcnt == '0);
      out_eop   <= w_pass & w_last;
      sym_err   <= w_sop & (r_state != S_IDLE);
      if (w_pass) begin
        out_i <= in_i;
        out_q <= in_q;
      end
      if (w_sop) begin
        // sop is k=0 and always dropped; with D=1 the
        // very next sample is already the first useful one
        r_bo   <= backoff;
        r_d    <= w_d;
        r_k    <= KW'(1);
        r_pcnt <= '0;
        r_state <= (w_d == (BW+1)'(1)) ? S_PASS : S_SKIP;
      end else if (w_acc) begin
        unique case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          S_SKIP: begin
            r_k <= r_k + KW'(1);
            if (w_skip_end)
              r_state <= S_PASS;
          end
          S_PASS: begin
            r_k <= r_k + KW'(1);
            if (w_last) begin
              r_pcnt  <= '0;
              r_state <= (r_bo != '0) ? S_TAIL
                                      : S_IDLE;
            end else begin
              r_pcnt <= r_pcnt + PW'(1);
            end
          end
          S_TAIL: begin
            r_k <= r_k + KW'(1);
            if (w_tail_end)
              r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp_remove.sv
// tb_cp_remove: directed bench for cp_remove with in_i = base+k,
// in_q = -(base+k) so every output beat identifies its source sample.
module tb_cp_remove;

  localparam int N  = 1024;
  localparam int CP = 32;
  localparam int CL = CP + N;
  localparam int DW = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic in_valid = 1'b0;
  logic in_sop = 1'b0;
  logic signed [DW-1:0] in_i = '0;
  logic signed [DW-1:0] in_q = '0;
  logic [4:0] backoff = '0;
  logic out_valid, out_sop, out_eop, sym_err;
  logic signed [DW-1:0] out_i, out_q;

  cp_remove #(.N_FFT(N), .CP_LEN(CP), .DW(DW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_sop(in_sop),
    .in_i(in_i), .in_q(in_q), .backoff(backoff),
    .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .out_i(out_i), .out_q(out_q),
    .sym_err(sym_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sop;
    logic eop;
    logic [DW-1:0] i;
    logic [DW-1:0] q;
    int cyc;
  } beat_t;

  beat_t bq[$];
  int cyc = 0;
  int n_err = 0;
  int n_hold = 0;
  int n_orph = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic upd = 1'b0;
  logic [2*DW+3:0] prev = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    upd <= en | rst;
  end

  // record beats of enabled cycles; outputs must not move when en was low
  always @(negedge clk) begin
    if (upd) begin
      if (out_valid)
        bq.push_back('{out_sop, out_eop, out_i, out_q, cyc});
      if (sym_err)
        n_err++;
    end else if ({out_valid, out_sop, out_eop, sym_err, out_i, out_q} !== prev) begin
      n_hold++;
    end
    if ((out_sop | out_eop) & ~out_valid)
      n_orph++;
    prev = {out_valid, out_sop, out_eop, sym_err, out_i, out_q};
  end

  function automatic int xv(input int base, input int bo, input int j);
    return base + CP - bo + j;
  endfunction

  task automatic drive(input logic v, input logic s, input int val,
                       input logic [4:0] bo, input logic e);
    in_valid = v;
    in_sop = s;
    in_i = DW'(val);
    in_q = DW'(-val);
    backoff = bo;
    en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int base, input logic [4:0] bo,
                      input int k0, input int k1, input bit gaps);
    for (int k = k0; k <= k1; k++) begin
      if (gaps)
        while ($urandom_range(0, 99) < 30) begin
          if ($urandom_range(0, 1) == 1)
            drive(1'b0, 1'b1, -1, 5'd31, 1'b1);
          else
            drive(1'b1, 1'b1, -7, 5'd31, 1'b0);
        end
      drive(1'b1, k == 0, base + k, (k == 0) ? bo : 5'(k * 7), 1'b1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 5'd0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    n_err = 0;
    n_hold = 0;
    n_orph = 0;
    bq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 55, 5'd3, 1'b0);
    drive(1'b1, 1'b1, 56, 5'd3, 1'b0);
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_chk++;
    if (out_sop !== 1'b0) begin n_fail++; $display("FAIL rst_sop got %b want 0", out_sop); end
    n_chk++;
    if (out_eop !== 1'b0) begin n_fail++; $display("FAIL rst_eop got %b want 0", out_eop); end
    n_chk++;
    if (sym_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", sym_err); end
    n_chk++;
    if (out_i !== '0) begin n_fail++; $display("FAIL rst_i got %0d want 0", out_i); end
    n_chk++;
    if (out_q !== '0) begin n_fail++; $display("FAIL rst_q got %0d want 0", out_q); end
    rst = 1'b0;
    bq.delete();
    n_err = 0;
    send(0, 5'd0, 1, 60, 0);
    idle(3);
    n_chk++;
    if (bq.size() != 0) begin n_fail++; $display("FAIL rst_nosop beats got %0d want 0", bq.size()); end
  endtask

  task automatic test_bo0();
    int t0;
    int bad;
    do_reset();
    t0 = cyc;
    send(0, 5'd0, 0, CL - 1, 0);
    idle(3);
    n_chk++;
    if (bq.size() != N) begin n_fail++; $display("FAIL bo0_count got %0d want %0d", bq.size(), N); end
    if (bq.size() >= N) begin
      bad = -1;
      for (int j = 0; j < N; j++)
        if (bq[j].i !== DW'(xv(0, 0, j)) || bq[j].q !== DW'(-xv(0, 0, j)) ||
            bq[j].sop !== (j == 0) || bq[j].eop !== (j == N - 1))
          if (bad < 0) bad = j;
      n_chk++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL bo0_data beat %0d got i=%0d sop=%b eop=%b want i=%0d",
                 bad, bq[bad].i, bq[bad].sop, bq[bad].eop, xv(0, 0, bad));
      end
      n_chk++;
      if (bq[0].cyc - t0 != 33) begin n_fail++; $display("FAIL bo0_latency got %0d want 33", bq[0].cyc - t0); end
    end
    n_chk++;
    if (out_i !== DW'(1055)) begin n_fail++; $display("FAIL bo0_hold got %0d want 1055", out_i); end
    n_chk++;
    if (n_err != 0) begin n_fail++; $display("FAIL bo0_err got %0d want 0", n_err); end
  endtask

  task automatic test_bo8();
    int bad;
    do_reset();
    send(0, 5'd8, 0, CL - 1, 0);
    idle(3);
    n_chk++;
    if (bq.size() != N) begin n_fail++; $display("FAIL bo8_count got %0d want %0d", bq.size(), N); end
    if (bq.size() >= N) begin
      bad = -1;
      for (int j = 0; j < N; j++)
        if (bq[j].i !== DW'(xv(0, 8, j)) || bq[j].q !== DW'(-xv(0, 8, j)) ||
            bq[j].sop !== (j == 0) || bq[j].eop !== (j == N - 1))
          if (bad < 0) bad = j;
      n_chk++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL bo8_data beat %0d got i=%0d sop=%b eop=%b want i=%0d",
                 bad, bq[bad].i, bq[bad].sop, bq[bad].eop, xv(0, 8, bad));
      end
    end
    // a sop right after k=1055 must be taken from IDLE, not TAIL
    send(3000, 5'd0, 0, 0, 0);
    idle(2);
    n_chk++;
    if (n_err != 0) begin n_fail++; $display("FAIL bo8_idle err got %0d want 0", n_err); end
  endtask

  task automatic test_back_to_back();
    int bad;
    int base [3] = '{0, 2000, 4000};
    int bo [3] = '{0, 31, 5};
    do_reset();
    for (int s = 0; s < 3; s++)
      send(base[s], 5'(bo[s]), 0, CL - 1, 0);
    idle(3);
    n_chk++;
    if (bq.size() != 3 * N) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", bq.size(), 3 * N); end
    if (bq.size() >= 3 * N)
      for (int s = 0; s < 3; s++) begin
        bad = -1;
        for (int j = 0; j < N; j++)
          if (bq[s*N+j].i !== DW'(xv(base[s], bo[s], j)) ||
              bq[s*N+j].q !== DW'(-xv(base[s], bo[s], j)) ||
              bq[s*N+j].sop !== (j == 0) || bq[s*N+j].eop !== (j == N - 1))
            if (bad < 0) bad = j;
        n_chk++;
        if (bad >= 0) begin
          n_fail++;
          $display("FAIL b2b_data sym %0d beat %0d got i=%0d sop=%b eop=%b want i=%0d",
                   s, bad, bq[s*N+bad].i, bq[s*N+bad].sop, bq[s*N+bad].eop,
                   xv(base[s], bo[s], bad));
        end
      end
    n_chk++;
    if (n_err != 0) begin n_fail++; $display("FAIL b2b_err got %0d want 0", n_err); end
    n_chk++;
    if (n_orph != 0) begin n_fail++; $display("FAIL b2b_orphan got %0d want 0", n_orph); end
  endtask

  task automatic test_gaps();
    int bad;
    int base [2] = '{100, 9000};
    int bo [2] = '{3, 17};
    do_reset();
    for (int s = 0; s < 2; s++)
      send(base[s], 5'(bo[s]), 0, CL - 1, 1);
    idle(3);
    n_chk++;
    if (bq.size() != 2 * N) begin n_fail++; $display("FAIL gaps_count got %0d want %0d", bq.size(), 2 * N); end
    if (bq.size() >= 2 * N)
      for (int s = 0; s < 2; s++) begin
        bad = -1;
        for (int j = 0; j < N; j++)
          if (bq[s*N+j].i !== DW'(xv(base[s], bo[s], j)) ||
              bq[s*N+j].q !== DW'(-xv(base[s], bo[s], j)) ||
              bq[s*N+j].sop !== (j == 0) || bq[s*N+j].eop !== (j == N - 1))
            if (bad < 0) bad = j;
        n_chk++;
        if (bad >= 0) begin
          n_fail++;
          $display("FAIL gaps_data sym %0d beat %0d got i=%0d sop=%b eop=%b want i=%0d",
                   s, bad, bq[s*N+bad].i, bq[s*N+bad].sop, bq[s*N+bad].eop,
                   xv(base[s], bo[s], bad));
        end
      end
    n_chk++;
    if (n_err != 0) begin n_fail++; $display("FAIL gaps_err got %0d want 0", n_err); end
    n_chk++;
    if (n_hold != 0) begin n_fail++; $display("FAIL gaps_hold changes got %0d want 0", n_hold); end
    n_chk++;
    if (n_orph != 0) begin n_fail++; $display("FAIL gaps_orphan got %0d want 0", n_orph); end
  endtask

  task automatic test_sop_err();
    int bad;
    int nold;
    nold = 500 - CP;
    do_reset();
    send(0, 5'd0, 0, 499, 0);
    send(5000, 5'd0, 0, CL - 1, 0);
    idle(3);
    n_chk++;
    if (bq.size() != nold + N) begin n_fail++; $display("FAIL soperr_count got %0d want %0d", bq.size(), nold + N); end
    if (bq.size() >= nold + N) begin
      bad = -1;
      for (int j = 0; j < nold; j++)
        if (bq[j].i !== DW'(xv(0, 0, j)) || bq[j].sop !== (j == 0) || bq[j].eop !== 1'b0)
          if (bad < 0) bad = j;
      n_chk++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL soperr_old beat %0d got i=%0d sop=%b eop=%b want i=%0d eop=0",
                 bad, bq[bad].i, bq[bad].sop, bq[bad].eop, xv(0, 0, bad));
      end
      bad = -1;
      for (int j = 0; j < N; j++)
        if (bq[nold+j].i !== DW'(xv(5000, 0, j)) || bq[nold+j].q !== DW'(-xv(5000, 0, j)) ||
            bq[nold+j].sop !== (j == 0) || bq[nold+j].eop !== (j == N - 1))
          if (bad < 0) bad = j;
      n_chk++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL soperr_new beat %0d got i=%0d sop=%b eop=%b want i=%0d",
                 bad, bq[nold+bad].i, bq[nold+bad].sop, bq[nold+bad].eop, xv(5000, 0, bad));
      end
    end
    n_chk++;
    if (n_err != 1) begin n_fail++; $display("FAIL soperr_pulses got %0d want 1", n_err); end
  endtask

  task automatic test_rst_mid();
    int bad;
    do_reset();
    send(0, 5'd0, 0, CP + 300, 0);
    rst = 1'b1;
    drive(1'b1, 1'b1, 777, 5'd0, 1'b0);
    n_chk++;
    if ({out_valid, out_sop, out_eop, sym_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL rstmid_strobes got %b want 0000", {out_valid, out_sop, out_eop, sym_err});
    end
    n_chk++;
    if ({out_i, out_q} !== '0) begin n_fail++; $display("FAIL rstmid_data got i=%0d q=%0d want 0", out_i, out_q); end
    rst = 1'b0;
    send(50, 5'd0, 1, 60, 0);
    idle(3);
    n_chk++;
    if (bq.size() != 301) begin n_fail++; $display("FAIL rstmid_nosop beats got %0d want 301", bq.size()); end
    send(7000, 5'd2, 0, CL - 1, 0);
    idle(3);
    n_chk++;
    if (bq.size() != 301 + N) begin n_fail++; $display("FAIL rstmid_count got %0d want %0d", bq.size(), 301 + N); end
    if (bq.size() >= 301 + N) begin
      bad = -1;
      for (int j = 0; j < 301; j++)
        if (bq[j].i !== DW'(xv(0, 0, j)) || bq[j].eop !== 1'b0)
          if (bad < 0) bad = j;
      n_chk++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL rstmid_old beat %0d got i=%0d eop=%b want i=%0d eop=0",
                 bad, bq[bad].i, bq[bad].eop, xv(0, 0, bad));
      end
      bad = -1;
      for (int j = 0; j < N; j++)
        if (bq[301+j].i !== DW'(xv(7000, 2, j)) || bq[301+j].q !== DW'(-xv(7000, 2, j)) ||
            bq[301+j].sop !== (j == 0) || bq[301+j].eop !== (j == N - 1))
          if (bad < 0) bad = j;
      n_chk++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL rstmid_new beat %0d got i=%0d sop=%b eop=%b want i=%0d",
                 bad, bq[301+bad].i, bq[301+bad].sop, bq[301+bad].eop, xv(7000, 2, bad));
      end
    end
    n_chk++;
    if (n_err != 0) begin n_fail++; $display("FAIL rstmid_err got %0d want 0", n_err); end
  endtask

  initial begin
    test_reset();
    test_bo0();
    test_bo8();
    test_back_to_back();
    test_gaps();
    test_sop_err();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
